parity_serial_rx: RTL and testbench

- Receive side of the team's XOR-parity serial link. Deserialises single-wire frames: start bit, DATA_W data bits sent LSB first, one parity bit, one stop bit.
- Checks parity using an XOR reduction over the data bits and the parity bit.
- Sits between the pad/loopback wire and the consumer logic, which reads one data word per frame with its error flags.

---
 rtl/parity_serial_rx_if.sv | 29 ++
 rtl/parity_serial_rx.sv | 133 +++++++++++++
 tb/tb_parity_serial_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/parity_serial_rx_if.sv
// parity_serial_rx_if: serial line plus received-word bus between the link and its consumer
interface parity_serial_rx_if #(
    parameter int DATA_W = 8
);
    logic              rxd;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output rxd,
        input  data_out,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rxd,
        output data_out,
        output valid,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/parity_serial_rx.sv
// parity_serial_rx: deserialises start/data(LSB first)/parity/stop frames and flags parity and framing errors
module parity_serial_rx #(
    parameter int DATA_W = 8,
    parameter int DIV    = 4,
    parameter int ODD    = 0
) (
    input logic               clk,
    input logic               rst_n,
    parity_serial_rx_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state;
    logic [1:0]        r_sync;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_sh;
    logic              r_par;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              r_busy;
    logic              w_rxd_s;
    logic              w_bit_end;

    assign w_rxd_s   = r_sync[1];
    assign w_bit_end = (r_cnt == CW'(DIV - 1));

    assign bus.data_out   = r_data;
    assign bus.valid      = r_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = r_busy;

    // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], bus.rxd};
    end

    // Frame FSM: mid-bit sampling, shift-in LSB first, running parity, one-cycle result strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_sh         <= '0;
            r_par        <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rxd_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == CW'(DIV / 2 - 1)) begin
                        r_cnt <= '0;
                        if (w_rxd_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                            r_par   <= 1'(ODD);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_sh  <= (r_sh >> 1) | (DATA_W'(w_rxd_s) << (DATA_W - 1));
                        r_par <= r_par ^ w_rxd_s;
                        r_idx <= r_idx + 1'b1;
                        r_cnt <= '0;
                        if (r_idx == IW'(DATA_W - 1)) r_state <= S_PARITY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_par   <= r_par ^ w_rxd_s;
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop gives half a bit of slack to catch a back-to-back start edge
                    if (w_bit_end) begin
                        r_data       <= r_sh;
                        r_parity_err <= r_par;
                        r_frame_err  <= ~w_rxd_s;
                        r_valid      <= 1'b1;
                        r_cnt        <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_parity_serial_rx.sv
// tb_parity_serial_rx: directed frames into even- and odd-parity receivers sharing one line
module tb_parity_serial_rx;
    localparam int DATA_W = 8;
    localparam int DIV    = 4;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              pe;
        logic              fe;
        int unsigned       t;
    } rec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd   = 1'b1;
    int unsigned cyc   = 0;
    int unsigned t_start;
    int          checks = 0;
    int          errors = 0;
    rec_t        q [2][$];
    rec_t        last;
    rec_t        first;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parity_serial_rx_if #(.DATA_W(DATA_W)) if0 ();
    parity_serial_rx_if #(.DATA_W(DATA_W)) if1 ();
    assign if0.rxd = rxd;
    assign if1.rxd = rxd;

    parity_serial_rx #(.DATA_W(DATA_W), .DIV(DIV), .ODD(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    parity_serial_rx #(.DATA_W(DATA_W), .DIV(DIV), .ODD(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // Record every valid strobe with its flags and cycle stamp
    always @(negedge clk) begin
        rec_t r;
        if (if0.valid) begin
            r.d = if0.data_out; r.pe = if0.parity_err; r.fe = if0.frame_err; r.t = cyc;
            q[0].push_back(r);
        end
        if (if1.valid) begin
            r.d = if1.data_out; r.pe = if1.parity_err; r.fe = if1.frame_err; r.t = cyc;
            q[1].push_back(r);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop(input int u, input string tag, input logic [DATA_W-1:0] d, input logic pe, input logic fe);
        check({tag, "_present"}, 32'(q[u].size() > 0), 1);
        if (q[u].size() > 0) begin
            last = q[u].pop_front();
            check({tag, "_data"}, 32'(last.d), 32'(d));
            check({tag, "_perr"}, 32'(last.pe), 32'(pe));
            check({tag, "_ferr"}, 32'(last.fe), 32'(fe));
        end
    endtask

    task automatic none_left(input string tag);
        check({tag, "_extra0"}, q[0].size(), 0);
        check({tag, "_extra1"}, q[1].size(), 0);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s);
        t_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_data"},  32'(if0.data_out), 0);
        check({tag, "_valid"}, 32'(if0.valid), 0);
        check({tag, "_perr"},  32'(if0.parity_err), 0);
        check({tag, "_ferr"},  32'(if0.frame_err), 0);
        check({tag, "_busy"},  32'(if0.busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        outputs_zero("rst");
        rst_n = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b0, 1'b1);
        idle(10);
        pop(0, "a5_even", 8'hA5, 1'b0, 1'b0);
        check("a5_latency", 32'((last.t - t_start >= 44) && (last.t - t_start <= 46)), 1);
        pop(1, "a5_odd_p0", 8'hA5, 1'b1, 1'b0);
        check("a5_busy", 32'(if0.busy), 0);
        none_left("a5");

        send_frame(8'hA5, 1'b1, 1'b1);
        idle(10);
        pop(0, "a5p1_even", 8'hA5, 1'b1, 1'b0);
        pop(1, "a5p1_odd", 8'hA5, 1'b0, 1'b0);
        none_left("a5p1");

        send_frame(8'h3C, 1'b0, 1'b0);
        idle(12);
        pop(0, "3c_even", 8'h3C, 1'b0, 1'b1);
        pop(1, "3c_odd", 8'h3C, 1'b1, 1'b1);
        none_left("3c");
        check("3c_busy", 32'(if0.busy), 0);

        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (DIV / 2 + 3 + 2) @(negedge clk);
        check("glitch_busy", 32'(if0.busy), 0);
        check("glitch_hold", 32'(if0.data_out), 32'h3C);
        none_left("glitch");

        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(10);
        pop(0, "b2b_00", 8'h00, 1'b0, 1'b0);
        first = last;
        pop(0, "b2b_ff", 8'hFF, 1'b0, 1'b0);
        check("b2b_gap", last.t - first.t, (DATA_W + 3) * DIV);
        pop(1, "b2b_00_odd", 8'h00, 1'b1, 1'b0);
        pop(1, "b2b_ff_odd", 8'hFF, 1'b1, 1'b0);
        none_left("b2b");

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_before", 32'(if0.busy), 1);
        rst_n = 1'b0;
        #1;
        outputs_zero("abort_rst");
        repeat (3) @(negedge clk);
        outputs_zero("abort_hold");
        rxd = 1'b1;
        rst_n = 1'b1;
        idle(10);
        none_left("abort");
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(10);
        pop(0, "5a_even", 8'h5A, 1'b0, 1'b0);
        pop(1, "5a_odd", 8'h5A, 1'b1, 1'b0);
        none_left("5a");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
